pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline stage register that succeeds the fixed enable-based IF/ID latch. It carries an arbitrary-width payload between two pipeline stages under a valid/ready handshake, with an optional 2-entry skid buffer that fully registers backpressure. It also provides a synchronous flush that inserts a bubble. One instance sits between each pair of stages (IF/ID, ID/EX, ...), with the payload being the packed stage bundle, e.g. {pc, instr} for IF/ID.

---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage register with an optional 2-entry skid buffer.
// SKID=1 registers in_ready; SKID=0 is a single register with combinational in_ready.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  main_data_q;
    logic [DATA_W-1:0]  skid_data_q;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;
    logic               skid_v;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register; the valid bits are encoded in the state.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decode.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire) begin
                    if (SKID) begin
                        load_skid = 1'b1;
                        state_d   = ST_SKID;
                    end else begin
                        load_main_in = 1'b1;
                    end
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Outputs decoded from registered state (plus out_ready when SKID=0).
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        skid_v    = (state_q == ST_SKID);
        occupancy = 2'(out_valid) + 2'(skid_v);
        if (reset) begin
            in_ready = 1'b0;
        end else if (SKID) begin
            in_ready = !skid_v;
        end else begin
            in_ready = !out_valid || out_ready;
        end
    end

    // Payload storage; skid contents are don't-care while the skid slot is empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_data_q <= '0;
        end else if (load_main_in) begin
            main_data_q <= in_data;
        end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_q <= in_data;
        end
    end

    assign out_data = main_data_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and constrained-random checks of pipe_stage_skid in both SKID modes.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        iv1, or1, ir1, ov1;
    logic [63:0] id1, od1;
    logic [1:0]  oc1;

    logic        iv0, or0, ir0, ov0;
    logic [95:0] id0, od0;
    logic [1:0]  oc0;

    int nvec;
    int nerr;

    pipe_stage_skid #(.DATA_W(64), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1)
    );

    pipe_stage_skid #(.DATA_W(96), .SKID(1'b0)) u_reg (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(oc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic [95:0] d, input logic r);
        if (sel) begin
            iv1 = v; id1 = d[63:0]; or1 = r;
        end else begin
            iv0 = v; id0 = d; or0 = r;
        end
    endtask

    function automatic logic get_ir(input bit sel);
        return sel ? ir1 : ir0;
    endfunction

    function automatic logic get_ov(input bit sel);
        return sel ? ov1 : ov0;
    endfunction

    function automatic logic [95:0] get_od(input bit sel);
        return sel ? {32'h0, od1} : od0;
    endfunction

    function automatic logic [1:0] get_oc(input bit sel);
        return sel ? oc1 : oc0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        nvec++;
        if (ir1 !== 1'b0 || ir0 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b/%b want 0/0", ir1, ir0);
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (ov1 !== 1'b0 || od1 !== 64'h0 || oc1 !== 2'd0 || ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state_skid: ov=%b od=%h oc=%0d ir=%b want 0 0 0 1", ov1, od1, oc1, ir1);
        end
        nvec++;
        if (ov0 !== 1'b0 || od0 !== 96'h0 || oc0 !== 2'd0 || ir0 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state_reg: ov=%b od=%h oc=%0d ir=%b want 0 0 0 1", ov0, od0, oc0, ir0);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b1, 96'h0000_1000_E3A0_0001, 1'b1);
        step();
        nvec++;
        if (ov1 !== 1'b1 || od1 !== 64'h0000_1000_E3A0_0001 || oc1 !== 2'd1 || ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL stream_first: ov=%b od=%h oc=%0d ir=%b want 1 0000_1000_E3A0_0001 1 1", ov1, od1, oc1, ir1);
        end
        drive(1'b1, 1'b1, 96'h0000_1004_E3A0_0002, 1'b1);
        step();
        nvec++;
        if (ov1 !== 1'b1 || od1 !== 64'h0000_1004_E3A0_0002 || oc1 !== 2'd1 || ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL stream_second: ov=%b od=%h oc=%0d ir=%b want 1 0000_1004_E3A0_0002 1 1", ov1, od1, oc1, ir1);
        end
        drive(1'b1, 1'b0, 96'h0, 1'b1);
        step();
        nvec++;
        if (ov1 !== 1'b0 || oc1 !== 2'd0) begin
            nerr++;
            $display("FAIL stream_drain: ov=%b oc=%0d want 0 0", ov1, oc1);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 96'hA, 1'b1);
        step();
        drive(1'b1, 1'b1, 96'hB, 1'b0);
        #1;
        nvec++;
        if (ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL bp_ready_before_absorb: got %b want 1", ir1);
        end
        step();
        nvec++;
        if (ov1 !== 1'b1 || od1 !== 64'hA || oc1 !== 2'd2 || ir1 !== 1'b0) begin
            nerr++;
            $display("FAIL bp_absorb: ov=%b od=%h oc=%0d ir=%b want 1 A 2 0", ov1, od1, oc1, ir1);
        end
        drive(1'b1, 1'b1, 96'hC, 1'b0);
        step();
        nvec++;
        if (od1 !== 64'hA || oc1 !== 2'd2 || ir1 !== 1'b0) begin
            nerr++;
            $display("FAIL bp_hold: od=%h oc=%0d ir=%b want A 2 0", od1, oc1, ir1);
        end
        drive(1'b1, 1'b1, 96'hC, 1'b1);
        step();
        nvec++;
        if (ov1 !== 1'b1 || od1 !== 64'hB || oc1 !== 2'd1 || ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release_b: ov=%b od=%h oc=%0d ir=%b want 1 B 1 1", ov1, od1, oc1, ir1);
        end
        step();
        nvec++;
        if (ov1 !== 1'b1 || od1 !== 64'hC || oc1 !== 2'd1) begin
            nerr++;
            $display("FAIL bp_release_c: ov=%b od=%h oc=%0d want 1 C 1", ov1, od1, oc1);
        end
        drive(1'b1, 1'b0, 96'h0, 1'b1);
        step();
        nvec++;
        if (ov1 !== 1'b0 || oc1 !== 2'd0) begin
            nerr++;
            $display("FAIL bp_empty: ov=%b oc=%0d want 0 0", ov1, oc1);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 96'hD, 1'b0);
        step();
        drive(1'b1, 1'b1, 96'hE, 1'b0);
        step();
        drive(1'b1, 1'b1, 96'hF, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, 1'b0, 96'h0, 1'b1);
        #1;
        nvec++;
        if (ov1 !== 1'b0 || od1 !== 64'h0 || oc1 !== 2'd0 || ir1 !== 1'b1) begin
            nerr++;
            $display("FAIL flush_state: ov=%b od=%h oc=%0d ir=%b want 0 0 0 1", ov1, od1, oc1, ir1);
        end
        step();
        step();
        nvec++;
        if (ov1 !== 1'b0) begin
            nerr++;
            $display("FAIL flush_no_ghost: ov=%b od=%h want ov 0", ov1, od1);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b1, 96'h11, 1'b0);
        step();
        drive(1'b1, 1'b1, 96'h22, 1'b0);
        step();
        drive(1'b1, 1'b0, 96'h0, 1'b1);
        reset = 1'b1;
        step();
        nvec++;
        if (ov1 !== 1'b0 || od1 !== 64'h0 || ir1 !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset_during: ov=%b od=%h ir=%b want 0 0 0", ov1, od1, ir1);
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (ir1 !== 1'b1 || oc1 !== 2'd0) begin
            nerr++;
            $display("FAIL mid_reset_after: ir=%b oc=%0d want 1 0", ir1, oc1);
        end
        step();
        nvec++;
        if (ov1 !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset_no_ghost: ov=%b od=%h want ov 0", ov1, od1);
        end
    endtask

    task automatic test_noskid();
        drive(1'b0, 1'b1, 96'hAAAA_0000_0000_0000_0000_0001, 1'b0);
        step();
        drive(1'b0, 1'b1, 96'hBBBB_0000_0000_0000_0000_0002, 1'b0);
        #1;
        nvec++;
        if (ir0 !== 1'b0 || oc0 !== 2'd1 || od0 !== 96'hAAAA_0000_0000_0000_0000_0001) begin
            nerr++;
            $display("FAIL noskid_stall: ir=%b oc=%0d od=%h want 0 1 AAAA..01", ir0, oc0, od0);
        end
        or0 = 1'b1;
        #1;
        nvec++;
        if (ir0 !== 1'b1) begin
            nerr++;
            $display("FAIL noskid_comb_ready: got %b want 1", ir0);
        end
        step();
        nvec++;
        if (ov0 !== 1'b1 || od0 !== 96'hBBBB_0000_0000_0000_0000_0002 || oc0 !== 2'd1) begin
            nerr++;
            $display("FAIL noskid_replace: ov=%b od=%h oc=%0d want 1 BBBB..02 1", ov0, od0, oc0);
        end
        drive(1'b0, 1'b0, 96'h0, 1'b1);
        step();
        nvec++;
        if (ov0 !== 1'b0 || oc0 !== 2'd0) begin
            nerr++;
            $display("FAIL noskid_empty: ov=%b oc=%0d want 0 0", ov0, oc0);
        end
    endtask

    task automatic test_random(input bit sel, input int ncyc);
        logic [95:0] q[$];
        logic [95:0] dat;
        logic [95:0] exp;
        logic [95:0] prev_od;
        logic        ivl;
        logic        ordy;
        logic        prev_stall;
        int          errs_before;
        ivl        = 1'b0;
        dat        = '0;
        prev_od    = '0;
        prev_stall = 1'b0;
        errs_before = nerr;
        for (int i = 0; i < ncyc + 40; i++) begin
            if (i < ncyc) begin
                ordy = ($urandom_range(0, 3) != 0) || (i % 97 > 80);
                ordy = ordy && !(i % 97 < 6);
                if (!ivl) begin
                    ivl = ($urandom_range(0, 2) != 0);
                    dat = {$urandom, $urandom, $urandom};
                    if (sel) dat[95:64] = 32'h0;
                end
            end else begin
                ordy = 1'b1;
                ivl  = 1'b0;
            end
            drive(sel, ivl, dat, ordy);
            #1;
            if (prev_stall) begin
                nvec++;
                if (get_ov(sel) !== 1'b1 || get_od(sel) !== prev_od) begin
                    nerr++;
                    $display("FAIL rand_stable sel=%0d cyc=%0d: ov=%b od=%h want 1 %h", sel, i, get_ov(sel), get_od(sel), prev_od);
                end
            end
            if (i % 8 == 0) begin
                nvec++;
                if (sel ? (get_ir(sel) !== (get_oc(sel) != 2'd2))
                        : (get_ir(sel) !== (!get_ov(sel) || ordy))) begin
                    nerr++;
                    $display("FAIL rand_ready sel=%0d cyc=%0d: ir=%b oc=%0d", sel, i, get_ir(sel), get_oc(sel));
                end
            end
            if (get_ov(sel) === 1'b1 && ordy) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL rand_spurious sel=%0d cyc=%0d: got %h want nothing", sel, i, get_od(sel));
                end else begin
                    exp = q.pop_front();
                    if (get_od(sel) !== exp) begin
                        nerr++;
                        $display("FAIL rand_order sel=%0d cyc=%0d: got %h want %h", sel, i, get_od(sel), exp);
                    end
                end
            end
            if (ivl && get_ir(sel) === 1'b1) begin
                q.push_back(dat);
                ivl = 1'b0;
            end
            prev_stall = get_ov(sel) && !ordy;
            prev_od    = get_od(sel);
            step();
        end
        nvec++;
        if (q.size() != 0 || get_oc(sel) !== 2'd0) begin
            nerr++;
            $display("FAIL rand_drain sel=%0d: left=%0d oc=%0d want 0 0", sel, q.size(), get_oc(sel));
        end
        if (nerr != errs_before) $display("random sel=%0d saw %0d errors", sel, nerr - errs_before);
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1'b1;
        flush = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        iv0 = 1'b0; or0 = 1'b0; id0 = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_noskid();
        test_random(1'b1, 3000);
        test_random(1'b0, 3000);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
